// File: rtl/mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mac_rr_scheduler
// Brief    : Round-robin scheduler sharing one multiply-accumulate datapath
//            among NUM_REQ operand sources; emits one tagged sum per job.
// Revision : 1.0 - initial release
// ============================================================================
module mac_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int ACC_LEN = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [RES_W-1:0]          result_o,
    output logic [ID_W-1:0]           res_id_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_grant_init = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]      c_beat_last       = 8'(ACC_LEN - 1);
    localparam logic [ID_W:0]   c_num_req         = (ID_W + 1)'(NUM_REQ);

    state_t                r_state;
    logic [ID_W-1:0]       r_owner;
    logic [ID_W-1:0]       r_last_grant;
    logic [RES_W-1:0]      r_acc;
    logic [7:0]            r_beat_cnt;

    logic [DATA_W-1:0]     w_a [NUM_REQ];
    logic [DATA_W-1:0]     w_b [NUM_REQ];
    logic [2*DATA_W-1:0]   w_prod;
    logic [RES_W-1:0]      w_acc_next;
    logic                  w_beat;
    logic                  w_grant_vld;
    logic [ID_W-1:0]       w_grant_id;
    logic [NUM_REQ-1:0]    w_grant_onehot;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_a[k] = req_a_i[k*DATA_W +: DATA_W];
        assign w_b[k] = req_b_i[k*DATA_W +: DATA_W];
    end

    // Scan from farthest to nearest candidate so the nearest valid one after
    // last_grant is the final assignment and therefore wins.
    always_comb begin
        logic [ID_W:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        v_idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            v_idx = {1'b0, r_last_grant} + (ID_W + 1)'(i);
            if (v_idx >= c_num_req) begin
                v_idx = v_idx - c_num_req;
            end
            if (req_valid_i[v_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_grant_onehot = NUM_REQ'(1) << w_grant_id;

    // Product is zero-extended into the accumulator; the sum wraps.
    assign w_prod     = w_a[r_owner] * w_b[r_owner];
    assign w_acc_next = r_acc + RES_W'(w_prod);
    assign w_beat     = (r_state == S_BUSY) && req_valid_i[r_owner] && req_ready_o[r_owner];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_grant <= c_last_grant_init;
            r_acc        <= '0;
            r_beat_cnt   <= '0;
            req_ready_o  <= '0;
            res_valid_o  <= 1'b0;
            result_o     <= '0;
            res_id_o     <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_state     <= S_BUSY;
                        r_owner     <= w_grant_id;
                        r_acc       <= '0;
                        r_beat_cnt  <= '0;
                        req_ready_o <= w_grant_onehot;
                        busy_o      <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_beat) begin
                        r_acc      <= w_acc_next;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (r_beat_cnt == c_beat_last) begin
                            r_state     <= S_DONE;
                            req_ready_o <= '0;
                            res_valid_o <= 1'b1;
                            result_o    <= w_acc_next;
                            res_id_o    <= r_owner;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        r_state      <= S_IDLE;
                        res_valid_o  <= 1'b0;
                        r_last_grant <= r_owner;
                        busy_o       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    req_ready_o <= '0;
                    res_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_rr_scheduler
// Brief    : Directed self-checking bench for mac_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_rr_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic [1:0]  res_id;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    mac_rr_scheduler #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .RES_W   (16),
        .ACC_LEN (4)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .result_o    (result),
        .res_id_o    (res_id),
        .busy_o      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic do_beat(input int id, input logic [7:0] a, input logic [7:0] b, output int waited);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!req_ready[id] && waited < 40);
        if (!req_ready[id]) check_eq("beat_timeout", {31'd0, req_ready[id]}, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic finish_job(input string tag, input logic [15:0] exp_res,
                              input logic [1:0] exp_id, input int hold);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk_i);
            check_eq({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
            check_eq({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
            check_eq({tag, "_id"}, {30'd0, res_id}, {30'd0, exp_id});
            check_eq({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
            check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        res_ready = 1'b1;
        @(posedge clk_i);
        #1;
        res_ready = 1'b0;
        req_valid = '0;
        @(negedge clk_i);
        check_eq({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int njobs;
        logic [1:0] exp_id;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        apply_reset();

        @(negedge clk_i);
        check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
        check_eq("rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_id", {30'd0, res_id}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        // Test 1: requester 0, 1*2+3*4+5*6+7*8 = 100
        @(posedge clk_i);
        #1;
        do_beat(0, 8'd1, 8'd2, w);
        check_eq("t1_grant_latency", w, 32'd2);
        do_beat(0, 8'd3, 8'd4, w);
        do_beat(0, 8'd5, 8'd6, w);
        do_beat(0, 8'd7, 8'd8, w);
        req_valid[0] = 1'b0;
        finish_job("t1", 16'd100, 2'd0, 0);

        // Tests 3/4: 4*255*255 mod 2^16, result held while consumer stalls
        for (int i = 0; i < 4; i++) do_beat(1, 8'd255, 8'd255, w);
        req_valid[1] = 1'b0;
        finish_job("t3", 16'hF804, 2'd1, 5);

        // Test 5: owner 2 stalls mid-job while requester 3 waits
        req_a[31:24]  = 8'd9;
        req_b[31:24]  = 8'd9;
        req_valid[3]  = 1'b1;
        do_beat(2, 8'd10, 8'd20, w);
        do_beat(2, 8'd2, 8'd3, w);
        req_valid[2] = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("t5_owner_kept", {28'd0, req_ready}, 32'h4);
            check_eq("t5_no_result", {31'd0, res_valid}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        do_beat(2, 8'd4, 8'd5, w);
        do_beat(2, 8'd6, 8'd7, w);
        req_valid[2] = 1'b0;
        finish_job("t5", 16'd268, 2'd2, 0);

        // Test 6: last grant -> 0, abort requester 1 mid-job, then 0 must win over 2
        for (int i = 0; i < 4; i++) do_beat(0, 8'd1, 8'd1, w);
        req_valid[0] = 1'b0;
        finish_job("t6_pre", 16'd4, 2'd0, 0);
        do_beat(1, 8'd5, 8'd5, w);
        do_beat(1, 8'd5, 8'd5, w);
        rst_n = 1'b0;
        req_valid    = 4'b0101;
        req_a[7:0]   = 8'd2;
        req_b[7:0]   = 8'd2;
        req_a[23:16] = 8'd3;
        req_b[23:16] = 8'd3;
        @(negedge clk_i);
        check_eq("t6_rst_ready", {28'd0, req_ready}, 32'd0);
        check_eq("t6_rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("t6_rst_result", {16'd0, result}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("t6_first_grant", {28'd0, req_ready}, 32'h1);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) do_beat(0, 8'd2, 8'd2, w);
        req_valid[0] = 1'b0;
        finish_job("t6", 16'd16, 2'd0, 0);

        // Test 2: all requesters continuously valid, consumer always ready
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            req_a[k*8 +: 8] = 8'(k + 1);
            req_b[k*8 +: 8] = 8'd2;
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        njobs = 0;
        for (int c = 0; c < 60 && njobs < 5; c++) begin
            @(negedge clk_i);
            check_eq("t2_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
            if (res_valid) begin
                exp_id = 2'(njobs % 4);
                check_eq("t2_owner", {30'd0, res_id}, {30'd0, exp_id});
                check_eq("t2_result", {16'd0, result}, 32'd8 * (32'(exp_id) + 32'd1));
                njobs++;
            end
        end
        check_eq("t2_jobs", njobs, 32'd5);
        req_valid = '0;
        res_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
